// File: rtl/slc3_mem_responder.sv
// SLC-3 bus memory responder: accepts a request, waits WAIT_STATES cycles, pulses Ready.
// Define MEM_IO_EN to map address 0xFFFF onto switches (read) and the hex register (write).
module slc3_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              WE,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Ready,
  output logic              Busy,
  input  logic [15:0]       S,
  output logic [15:0]       HexOut
);

  // state   | meaning
  // IDLE    | no transaction, waiting for Req
  // WAIT    | request latched, counting wait states
  // RESP    | access committed, Ready pulses this cycle
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              lat_we;
  logic [15:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              cur_we;
  logic [15:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              commit;
  logic              io_hit;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && Req) begin
        lat_we    <= WE;
        lat_addr  <= Addr;
        lat_wdata <= WData;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (Req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!Req)            state_nxt = ST_IDLE;
        else if (cnt == 4'd0) state_nxt = ST_RESP;
        else                 cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state == ST_RESP);
    Busy  = (state != ST_IDLE);
  end

  // With zero wait states the commit edge is the acceptance edge, so use live inputs.
  always_comb begin
    cur_we    = (state == ST_IDLE) ? WE    : lat_we;
    cur_addr  = (state == ST_IDLE) ? Addr  : lat_addr;
    cur_wdata = (state == ST_IDLE) ? WData : lat_wdata;
    commit    = (state_nxt == ST_RESP) && !Reset;
  end

`ifdef MEM_IO_EN
  assign io_hit = (cur_addr == 16'hFFFF);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                         HexOut <= '0;
    else if (commit && cur_we && io_hit) HexOut <= 16'(cur_wdata);
  end
`else
  logic unused_io;
  assign io_hit    = 1'b0;
  assign HexOut    = '0;
  assign unused_io = ^{S, cur_addr[15:ADDR_W]};
`endif

  always_ff @(posedge Clk) begin
    if (commit && cur_we && !io_hit)
      mem[cur_addr[ADDR_W-1:0]] <= cur_wdata;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RData <= '0;
    end else if (commit && !cur_we) begin
`ifdef MEM_IO_EN
      if (io_hit) RData <= DATA_W'(S);
      else        RData <= mem[cur_addr[ADDR_W-1:0]];
`else
      RData <= mem[cur_addr[ADDR_W-1:0]];
`endif
    end
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder (WAIT_STATES=2, ADDR_W=8); covers both MEM_IO_EN builds.
module tb_slc3_mem_responder;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset, Req, WE;
  logic [15:0] Addr, WData, RData, S, HexOut;
  logic        Ready, Busy;

  int n_checks = 0;
  int n_errors = 0;

  slc3_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
    .RData(RData), .Ready(Ready), .Busy(Busy), .S(S), .HexOut(HexOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Req is raised just after a falling edge; Ready is expected WS+1 rising edges later.
  // Request fields are scrambled after acceptance to show they are ignored.
  task automatic xact(input string tag, input logic we, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] rd);
    int cyc;
    @(negedge Clk);
    WE = we; Addr = a; WData = d; Req = 1'b1;
    @(posedge Clk); @(negedge Clk);
    cyc = 1;
    WE = ~we; Addr = ~a; WData = ~d;
    while (!Ready && cyc < 20) begin
      @(posedge Clk); @(negedge Clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, WS + 1);
    rd  = RData;
    Req = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk({tag, "_ready_width"}, Ready, 1'b0);
    chk({tag, "_busy_after"}, Busy, 1'b0);
  endtask

  logic [15:0] rd, rd1, rd2;
  int cyc, seen_ready, gap;

  initial begin
    Reset = 1'b1; Req = 1'b0; WE = 1'b0; Addr = '0; WData = '0; S = 16'h00C3;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", Ready, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_rdata", RData, 16'h0000);
    chk("rst_hex", HexOut, 16'h0000);
    Reset = 1'b0;

    // Basic write then read, latency and pulse width
    xact("w3", 1'b1, 16'h0003, 16'h1234, rd);
    xact("r3", 1'b0, 16'h0003, 16'h0000, rd);
    chk("r3_data", rd, 16'h1234);
    xact("w9", 1'b1, 16'h0009, 16'h9999, rd);
    chk("write_keeps_rdata", RData, 16'h1234);

    // Address wrap
    xact("w5", 1'b1, 16'h0005, 16'hAAAA, rd);
    xact("r105", 1'b0, 16'h0105, 16'h0000, rd);
    chk("wrap_data", rd, 16'hAAAA);

    // Reset during WAIT drops the pending write
    xact("w10", 1'b1, 16'h0010, 16'h1111, rd);
    xact("r10a", 1'b0, 16'h0010, 16'h0000, rd);
    chk("r10a_data", rd, 16'h1111);
    @(negedge Clk);
    WE = 1'b1; Addr = 16'h0010; WData = 16'hBEEF; Req = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("mid_wait_busy", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort_rst_ready", Ready, 1'b0);
    chk("abort_rst_busy", Busy, 1'b0);
    chk("abort_rst_rdata", RData, 16'h0000);
    Req = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    xact("r10b", 1'b0, 16'h0010, 16'h0000, rd);
    chk("reset_drops_write", rd, 16'h1111);

    // Dropping Req during WAIT aborts with no Ready
    xact("w20", 1'b1, 16'h0020, 16'h7777, rd);
    @(negedge Clk);
    WE = 1'b1; Addr = 16'h0020; WData = 16'h5555; Req = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Req = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (Ready) seen_ready++;
    end
    chk("abort_no_ready", seen_ready, 0);
    xact("r20", 1'b0, 16'h0020, 16'h0000, rd);
    chk("abort_no_write", rd, 16'h7777);

    // Req held high across two reads
    xact("w1", 1'b1, 16'h0001, 16'h0A01, rd);
    xact("w2", 1'b1, 16'h0002, 16'h0B02, rd);
    @(negedge Clk);
    WE = 1'b0; Addr = 16'h0001; Req = 1'b1;
    cyc = 0;
    while (!Ready && cyc < 20) begin
      @(posedge Clk); @(negedge Clk);
      cyc++;
    end
    chk("b2b_first_latency", cyc, WS + 1);
    rd1  = RData;
    Addr = 16'h0002;
    gap  = 0;
    cyc  = 0;
    @(posedge Clk); @(negedge Clk);
    while (!Ready && cyc < 20) begin
      if (!Busy) gap++;
      @(posedge Clk); @(negedge Clk);
      cyc++;
    end
    rd2 = RData;
    Req = 1'b0;
    chk("b2b_first_data", rd1, 16'h0A01);
    chk("b2b_second_data", rd2, 16'h0B02);
    chk("b2b_idle_gap", gap, 1);
    chk("b2b_second_ready", Ready, 1'b1);
    @(posedge Clk); @(negedge Clk);

`ifdef MEM_IO_EN
    xact("wff", 1'b1, 16'h00FF, 16'h0F0F, rd);
    xact("rio", 1'b0, 16'hFFFF, 16'h0000, rd);
    chk("io_switch_read", rd, 16'h00C3);
    xact("wio", 1'b1, 16'hFFFF, 16'h1A2B, rd);
    chk("io_hex_write", HexOut, 16'h1A2B);
    xact("rff", 1'b0, 16'h00FF, 16'h0000, rd);
    chk("io_ram_untouched", rd, 16'h0F0F);
`else
    xact("wio", 1'b1, 16'hFFFF, 16'h1A2B, rd);
    xact("rio", 1'b0, 16'hFFFF, 16'h0000, rd);
    chk("ffff_roundtrip", rd, 16'h1A2B);
    xact("rff", 1'b0, 16'h00FF, 16'h0000, rd);
    chk("ffff_alias_ff", rd, 16'h1A2B);
    chk("hex_tied_zero", HexOut, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
